ifetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the single-cycle CPU core.
- Generates sequential fetch addresses and issues them to instruction memory over a valid/ready request channel.
- Collects in-order responses into a small FIFO and presents {instruction, pc} to the core over a valid/ready handshake.
- On a control-flow redirect it flushes the FIFO and discards stale in-flight responses.

---
 rtl/ifq_pkg.sv | 17 +
 rtl/ifq_fifo.sv | 56 +++++
 rtl/ifetch_queue.sv | 112 +++++++++++
 tb/tb_ifetch_queue.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// Shared types and helpers for the instruction-fetch queue.
// Entry type carries the fetched instruction word and the address it came from.
package ifq_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSN_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] insn;
    logic [XLEN-1:0] pc;
  } ifq_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous DEPTH-entry FIFO of fetched instructions with single-cycle flush.
// Latency: push visible at head one cycle later. Backpressure: push ignored when full, pop ignored when empty.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  ifq_entry_t             push_dat,
  input  logic                   pop,
  output ifq_entry_t             head_dat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ifq_entry_t    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush && !reset) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch front end: credit-limited sequential requests, in-order response FIFO, redirect flush with stale-response discard.
// Latency: response to inst_valid 1 cycle (0 with IFQ_BYPASS_EN). Backpressure: requests stop when FIFO + in-flight reach DEPTH.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] NOP_INSN = INSN_NOP
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  output logic [XLEN-1:0] pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   out_after_rsp;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     in_use;
  logic            fifo_empty;
  logic            fifo_full;
  logic            fifo_push;
  logic            fifo_pop;
  logic            req_fire;
  logic            rsp_keep;
  logic            bypass;
  ifq_entry_t      head;
  ifq_entry_t      push_dat;

  assign in_use         = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req_valid = !reset && !redirect_valid && (in_use < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign pc             = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response is kept only when no stale responses remain and no flush is under way.
  assign rsp_keep      = imem_rsp_valid && (discard == '0) && !redirect_valid && !reset;
  assign out_after_rsp = outstanding - CW'(imem_rsp_valid);

`ifdef IFQ_BYPASS_EN
  assign bypass = fifo_empty && rsp_keep;
`else
  assign bypass = 1'b0;
`endif

  assign inst_valid = !fifo_empty || bypass;
  assign fifo_pop   = !fifo_empty && inst_ready && !redirect_valid;
  assign fifo_push  = rsp_keep && !fifo_full && !(bypass && inst_ready);
  assign push_dat   = '{insn: imem_rsp_data, pc: rsp_pc};

  // When empty, inst_pc shows the address the next kept response will carry.
  always_comb begin
    inst_data = NOP_INSN;
    inst_pc   = rsp_pc;
    if (!fifo_empty) begin
      inst_data = head.insn;
      inst_pc   = head.pc;
    end else if (bypass) begin
      inst_data = imem_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= align_word(redirect_pc);
      rsp_pc      <= align_word(redirect_pc);
      outstanding <= out_after_rsp;
      discard     <= out_after_rsp;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (rsp_keep) rsp_pc <= rsp_pc + 32'd4;
      outstanding <= out_after_rsp + CW'(req_fire);
      if (imem_rsp_valid && (discard != '0)) discard <= discard - CW'(1);
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (fifo_push),
    .push_dat (push_dat),
    .pop      (fifo_pop),
    .head_dat (head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: directed scenarios push expected pcs, a monitor compares each delivered instruction.
// A second instance with RESET_PC near the top of the address space covers pc wrap-around.
`timescale 1ns/1ps
module tb_ifetch_queue;

  localparam logic [31:0] KEY = 32'hC0DE_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IFQ_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        mem_ready = 1'b0;
  logic        mem_hold = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic [31:0] pc;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_ready = 1'b0;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data = '0;
  logic        w_inst_valid;
  logic [31:0] w_inst_data;
  logic [31:0] w_inst_pc;
  logic [31:0] w_pc;

  logic [31:0] mq[$];
  logic [31:0] wq[$];
  logic [31:0] exp_req[$];
  logic [31:0] exp_inst[$];
  logic [31:0] w_exp[$];
  logic [31:0] e_pc;
  int total = 0, bad = 0, n_req = 0, w_n_req = 0, cyc = 0, n0 = 0;
  int lat_fire = -1, lat_inst = -1;
  bit lat_arm = 1'b0;

  ifetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4), .NOP_INSN(NOP)) u_dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(req_valid), .imem_req_addr(req_addr), .imem_req_ready(mem_ready),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .pc(pc)
  );

  ifetch_queue #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4), .NOP_INSN(NOP)) u_wrap (
    .clk(clk), .reset(reset), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr), .imem_req_ready(w_ready),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .inst_valid(w_inst_valid), .inst_data(w_inst_data), .inst_pc(w_inst_pc), .inst_ready(1'b1),
    .pc(w_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model drives responses at negedge; monitor samples 2ns before each rising edge.
  always @(negedge clk) begin
    rsp_valid = 1'b0; rsp_data = '0;
    w_rsp_valid = 1'b0; w_rsp_data = '0;
    if (!mem_hold && mq.size() > 0) begin rsp_valid = 1'b1; rsp_data = mq.pop_front() ^ KEY; end
    if (wq.size() > 0) begin w_rsp_valid = 1'b1; w_rsp_data = wq.pop_front() ^ KEY; end
    #3;
    cyc++;
    if (req_valid && mem_ready) begin
      mq.push_back(req_addr);
      n_req++;
      if (lat_arm && lat_fire < 0) lat_fire = cyc;
      if (exp_req.size() > 0) chk("req_addr", req_addr, exp_req.pop_front());
    end
    if (inst_valid && inst_ready && !redirect_valid && !reset) begin
      if (lat_arm && lat_inst < 0) lat_inst = cyc;
      if (exp_inst.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_inst: got pc %h data %h, none expected", inst_pc, inst_data);
      end else begin
        e_pc = exp_inst.pop_front();
        chk("inst_pc", inst_pc, e_pc);
        chk("inst_data", inst_data, e_pc ^ KEY);
      end
    end
    if (w_req_valid && w_ready) begin wq.push_back(w_req_addr); w_n_req++; end
    if (w_inst_valid && !reset) begin
      if (w_exp.size() == 0) begin
        total++; bad++;
        $display("FAIL wrap_unexpected_inst: got pc %h, none expected", w_inst_pc);
      end else begin
        e_pc = w_exp.pop_front();
        chk("wrap_inst_pc", w_inst_pc, e_pc);
        chk("wrap_inst_data", w_inst_data, e_pc ^ KEY);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int target, input string name);
    int k = 0;
    while (n_req < target && k < 200) begin @(posedge clk); k++; end
    #1;
    chk(name, n_req, target);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while ((exp_inst.size() + exp_req.size() + w_exp.size()) != 0 && k < budget) begin step(1); k++; end
    step(5);
    chk(name, exp_inst.size() + exp_req.size() + w_exp.size(), 0);
    exp_inst.delete(); exp_req.delete(); w_exp.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mq.delete(); wq.delete();
    step(2);
  endtask

  initial begin
    // Reset state
    step(2);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_data", inst_data, NOP);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_req_valid", req_valid, 0);
    chk("wrap_rst_pc", w_pc, 32'hFFFF_FFF8);

    // Streaming: 8 sequential fetches delivered in order
    for (int i = 0; i < 8; i++) begin exp_req.push_back(32'(i * 4)); exp_inst.push_back(32'(i * 4)); end
    mem_ready = 1'b1; inst_ready = 1'b1; lat_arm = 1'b1;
    reset = 1'b0;
    wait_req(8, "s1_req_count");
    mem_ready = 1'b0;
    wait_drain("s1_drain", 60);
    chk("s1_latency", lat_inst - lat_fire, EXP_LAT);
    chk("s1_next_pc", pc, 32'h20);
    lat_arm = 1'b0;

    // Consumer stalled: credit stops requests at DEPTH
    do_reset();
    inst_ready = 1'b0; mem_ready = 1'b1; n0 = n_req;
    reset = 1'b0;
    step(10);
    chk("s2_req_count", n_req - n0, 4);
    chk("s2_req_valid_stalled", req_valid, 0);
    chk("s2_inst_valid", inst_valid, 1);
    chk("s2_head_pc", inst_pc, 32'h0);
    for (int i = 0; i < 4; i++) exp_inst.push_back(32'(i * 4));
    mem_ready = 1'b0; inst_ready = 1'b1;
    step(1);
    chk("s2_req_valid_after_pop", req_valid, 1);
    wait_drain("s2_drain", 40);

    // Redirect with three requests in flight
    do_reset();
    mem_hold = 1'b1; mem_ready = 1'b1; inst_ready = 1'b1; n0 = n_req;
    reset = 1'b0;
    wait_req(n0 + 3, "s3_inflight");
    mem_ready = 1'b0;
    step(2);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102; mem_ready = 1'b1;
    #1;
    chk("s3_req_valid_in_redirect", req_valid, 0);
    exp_req.push_back(32'h100); exp_req.push_back(32'h104);
    exp_inst.push_back(32'h100); exp_inst.push_back(32'h104);
    step(1);
    redirect_valid = 1'b0; mem_hold = 1'b0;
    chk("s3_pc", pc, 32'h100);
    wait_req(n0 + 5, "s3_new_reqs");
    mem_ready = 1'b0;
    wait_drain("s3_drain", 40);

    // Response arriving in the redirect cycle, one more outstanding
    do_reset();
    mem_hold = 1'b1; mem_ready = 1'b1; inst_ready = 1'b1; n0 = n_req;
    reset = 1'b0;
    wait_req(n0 + 2, "s4_inflight");
    mem_ready = 1'b0;
    step(1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; mem_hold = 1'b0; mem_ready = 1'b1;
    exp_req.push_back(32'h200); exp_inst.push_back(32'h200);
    step(1);
    redirect_valid = 1'b0;
    wait_req(n0 + 3, "s4_new_req");
    mem_ready = 1'b0;
    wait_drain("s4_drain", 40);

    // Reset with a full FIFO
    do_reset();
    inst_ready = 1'b0; mem_ready = 1'b1;
    reset = 1'b0;
    step(8);
    chk("s5_full_valid", inst_valid, 1);
    reset = 1'b1; mq.delete();
    step(1);
    chk("s5_inst_valid", inst_valid, 0);
    chk("s5_inst_data", inst_data, NOP);
    chk("s5_inst_pc", inst_pc, 32'h0);
    chk("s5_pc", pc, 32'h0);
    chk("s5_req_valid", req_valid, 0);
    mem_ready = 1'b0; inst_ready = 1'b1;
    reset = 1'b0;
    step(3);
    chk("s5_after_inst_valid", inst_valid, 0);

    // Address wrap from RESET_PC = 0xFFFF_FFF8
    w_exp.push_back(32'hFFFF_FFF8); w_exp.push_back(32'hFFFF_FFFC); w_exp.push_back(32'h0000_0000);
    n0 = w_n_req;
    w_ready = 1'b1;
    for (int k = 0; k < 100 && w_n_req < n0 + 3; k++) @(posedge clk);
    #1;
    w_ready = 1'b0;
    chk("wrap_req_count", w_n_req - n0, 3);
    wait_drain("wrap_drain", 40);
    chk("wrap_next_pc", w_pc, 32'h0000_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
